key_led_ctrl: RTL and testbench

KEY_LED_CTRL -- requirements
Module: key_led_ctrl

---
 rtl/key_led_pkg.sv | 50 +++++
 rtl/key_debounce.sv | 57 +++++
 rtl/key_led_ctrl.sv | 53 +++++
 tb/tb_key_led_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_led_pkg.sv
// Shared mode encodings, LED start patterns and pattern helpers for the
// key-driven LED controller.
package key_led_pkg;

  localparam int KEY_W = 4;

  // Mode encodings double as the FSM state values.
  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_FLOW_L = 2'd1;
  localparam logic [1:0] MODE_FLOW_R = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic [3:0] PAT_OFF    = 4'b0000;
  localparam logic [3:0] PAT_FLOW_L = 4'b0001;
  localparam logic [3:0] PAT_FLOW_R = 4'b1000;
  localparam logic [3:0] PAT_BLINK  = 4'b1111;

  function automatic logic [3:0] init_pattern(input logic [1:0] m);
    logic [3:0] p;
    case (m)
      MODE_FLOW_L: p = PAT_FLOW_L;
      MODE_FLOW_R: p = PAT_FLOW_R;
      MODE_BLINK:  p = PAT_BLINK;
      default:     p = PAT_OFF;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] step_pattern(input logic [1:0] m, input logic [3:0] p);
    logic [3:0] n;
    case (m)
      MODE_FLOW_L: n = {p[2:0], p[3]};
      MODE_FLOW_R: n = {p[0], p[3:1]};
      MODE_BLINK:  n = ~p;
      default:     n = PAT_OFF;
    endcase
    return n;
  endfunction

  // Lowest key index wins when several presses land in the same cycle.
  function automatic logic [1:0] press_to_mode(input logic [KEY_W-1:0] kp);
    logic [1:0] m;
    if (kp[0])      m = MODE_FLOW_L;
    else if (kp[1]) m = MODE_FLOW_R;
    else if (kp[2]) m = MODE_BLINK;
    else            m = MODE_OFF;
    return m;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizer, shared-counter debounce and press-edge detect for the
// active-low key vector.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int DEB_CNT = 1_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_db,
  output logic [KEY_W-1:0] key_press
);

  localparam int             CNT_W   = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);

  logic [KEY_W-1:0] key_meta;
  logic [KEY_W-1:0] key_sync;
  logic [KEY_W-1:0] key_prev;
  logic [KEY_W-1:0] key_db_d;
  logic [CNT_W-1:0] deb_cnt;
  logic             stable;

  assign stable = (key_sync == key_prev);

  // NOTE: every register here uses non-blocking assignment so all flops
  // sample the pre-edge values; blocking would collapse the synchronizer chain.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta  <= '1;
      key_sync  <= '1;
      key_prev  <= '1;
      deb_cnt   <= '0;
      key_db    <= '1;
      key_db_d  <= '1;
      key_press <= '0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
      key_prev <= key_sync;

      if (!stable)
        deb_cnt <= '0;
      else if (deb_cnt != CNT_MAX)
        deb_cnt <= deb_cnt + 1'b1;

      // Only capture a vector that is still unchanged in this very cycle.
      if (deb_cnt == CNT_MAX && stable)
        key_db <= key_sync;

      key_db_d  <= key_db;
      key_press <= key_db_d & ~key_db;
    end
  end

endmodule

// File: rtl/key_led_ctrl.sv
// Four-mode LED pattern controller driven by debounced push-buttons.
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int DEB_CNT  = 1_000_000,
  parameter int STEP_CNT = 25_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [KEY_W-1:0] key,
  output logic [3:0]       led,
  output logic [1:0]       mode,
  output logic [KEY_W-1:0] key_press
);

  localparam int              STEP_W   = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_CNT - 1);

  logic [STEP_W-1:0] step_cnt;
  logic [1:0]        sel_mode;

  // The debounced level itself is not needed here, only the press pulses.
  key_debounce #(
    .DEB_CNT (DEB_CNT)
  ) u_key_debounce (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key       (key),
    .key_db    (),
    .key_press (key_press)
  );

  assign sel_mode = press_to_mode(key_press);

  // Any press, even of the current mode, restarts the pattern and its timer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode     <= MODE_OFF;
      led      <= PAT_OFF;
      step_cnt <= '0;
    end else if (|key_press) begin
      mode     <= sel_mode;
      led      <= init_pattern(sel_mode);
      step_cnt <= '0;
    end else if (step_cnt == STEP_MAX) begin
      step_cnt <= '0;
      led      <= step_pattern(mode, led);
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_key_led_ctrl.sv
// Scoreboard bench for key_led_ctrl: stimulus queues expected press events,
// a monitor matches each key_press pulse and the LED sequence that follows.
module tb_key_led_ctrl;

  typedef struct packed {
    logic [3:0]      kp;
    int              lo;
    int              hi;
    logic [1:0]      mode;
    logic [3:0]      led0;
    logic            chk_pre;
    logic [3:0]      pre;
    int              nsteps;
    logic [5:0][3:0] steps;
  } exp_t;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] key;
  logic [3:0] led;
  logic [1:0] mode;
  logic [3:0] key_press;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc;
  int   pulses = 0;
  bit   active = 1'b0;
  exp_t exp_q[$];

  key_led_ctrl #(
    .DEB_CNT  (10),
    .STEP_CNT (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key       (key),
    .led       (led),
    .mode      (mode),
    .key_press (key_press)
  );

  initial begin
    sys_clk = 1'b0;
    forever #10 sys_clk = ~sys_clk;
  end

  // Cycle index: first active edge after reset release is cycle 1.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Press expected d+13 cycles after the key level is first captured at edge d.
  task automatic push_exp(input logic [3:0] kp, input int d, input logic [1:0] m,
                          input logic [3:0] l0, input logic chk_pre, input logic [3:0] pre,
                          input int n, input logic [5:0][3:0] st);
    exp_t e;
    e.kp      = kp;
    e.lo      = d + 12;
    e.hi      = d + 14;
    e.mode    = m;
    e.led0    = l0;
    e.chk_pre = chk_pre;
    e.pre     = pre;
    e.nsteps  = n;
    e.steps   = st;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || active) && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 300) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Monitor: matches each pulse, then checks the load and later LED steps.
  initial begin
    exp_t cur;
    int   load_cyc;
    cur      = '0;
    load_cyc = 0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        active = 1'b0;
      end else begin
        if (key_press != 4'b0000) begin
          pulses++;
          if (exp_q.size() == 0) begin
            check("unexpected_press", {28'b0, key_press}, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            check("press_bits", {28'b0, key_press}, {28'b0, cur.kp});
            n_cmp++;
            if (cyc < cur.lo || cyc > cur.hi) begin
              n_fail++;
              $display("FAIL press_cycle: pulse at cycle %0d, required %0d..%0d", cyc, cur.lo, cur.hi);
            end
            if (cur.chk_pre) check("led_before_repress", {28'b0, led}, {28'b0, cur.pre});
            load_cyc = cyc + 1;
            active   = 1'b1;
          end
        end
        if (active) begin
          if (cyc == load_cyc) begin
            check("mode_after_press", {30'b0, mode}, {30'b0, cur.mode});
            check("led_after_press", {28'b0, led}, {28'b0, cur.led0});
          end
          for (int k = 1; k <= cur.nsteps; k++) begin
            if (cyc == load_cyc + 8 * k + 4) begin
              check("led_step", {28'b0, led}, {28'b0, cur.steps[k-1]});
              check("mode_hold", {30'b0, mode}, {30'b0, cur.mode});
            end
          end
          if (cyc >= load_cyc + 8 * cur.nsteps + 4) active = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d;
    int p;
    int n;
    sys_rst_n = 1'b0;
    key       = 4'b1111;
    #1;
    check("reset_led", {28'b0, led}, 32'd0);
    check("reset_mode", {30'b0, mode}, 32'd0);
    check("reset_key_press", {28'b0, key_press}, 32'd0);
    #19 sys_rst_n = 1'b1;

    // Idle: nothing pressed for 100 cycles.
    repeat (100) @(negedge sys_clk);
    check("idle_led", {28'b0, led}, 32'd0);
    check("idle_mode", {30'b0, mode}, 32'd0);
    check("idle_pulses", pulses, 32'd0);

    // Clean press of key[0]: FLOW_L rotating left.
    d = cyc + 1;
    push_exp(4'b0001, d, 2'd1, 4'b0001, 1'b0, 4'b0000, 4,
             {4'h0, 4'h0, 4'b0001, 4'b1000, 4'b0100, 4'b0010});
    key[0] = 1'b0;
    wait_idle("clean_press");
    key[0] = 1'b1;
    repeat (20) @(negedge sys_clk);

    // Bouncing key[1]: 3-cycle glitches, then settles low.
    for (int i = 0; i < 10; i++) begin
      key[1] = i[0];
      repeat (3) @(negedge sys_clk);
    end
    d = cyc + 1;
    push_exp(4'b0010, d, 2'd2, 4'b1000, 1'b0, 4'b0000, 2,
             {4'h0, 4'h0, 4'h0, 4'h0, 4'b0010, 4'b0100});
    key[1] = 1'b0;
    wait_idle("bounce");
    key[1] = 1'b1;
    repeat (20) @(negedge sys_clk);

    // key[2] and key[3] together: index 2 wins, BLINK.
    d = cyc + 1;
    push_exp(4'b1100, d, 2'd3, 4'b1111, 1'b0, 4'b0000, 3,
             {4'h0, 4'h0, 4'h0, 4'b0000, 4'b1111, 4'b0000});
    key[3:2] = 2'b00;
    wait_idle("simultaneous");
    key[3:2] = 2'b11;
    repeat (20) @(negedge sys_clk);

    // key[3] alone: back to OFF.
    d = cyc + 1;
    push_exp(4'b1000, d, 2'd0, 4'b0000, 1'b0, 4'b0000, 2,
             {4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000});
    key[3] = 1'b0;
    wait_idle("off_press");
    key[3] = 1'b1;
    repeat (20) @(negedge sys_clk);

    // FLOW_L again, then re-press key[0] while led shows 0100.
    d = cyc + 1;
    push_exp(4'b0001, d, 2'd1, 4'b0001, 1'b0, 4'b0000, 5,
             {4'h0, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010});
    key[0] = 1'b0;
    n = 0;
    while (!key_press[0] && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 40) check("first_flow_timeout", 32'd0, 32'd1);
    p = cyc;
    repeat (2) @(negedge sys_clk);
    key[0] = 1'b1;
    while (cyc < p + 38) @(negedge sys_clk);
    // Re-press lands at load+51, inside the 0100 window (load+48..load+55).
    d = cyc + 1;
    push_exp(4'b0001, d, 2'd1, 4'b0001, 1'b1, 4'b0100, 1,
             {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0010});
    key[0] = 1'b0;
    wait_idle("repress");
    key[0] = 1'b1;
    repeat (20) @(negedge sys_clk);

    // Reset pulse while key[1] is already held low.
    key[1] = 1'b0;
    repeat (3) @(negedge sys_clk);
    #5 sys_rst_n = 1'b0;
    push_exp(4'b0010, 1, 2'd2, 4'b1000, 1'b0, 4'b0000, 1,
             {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0100});
    #1;
    check("midrun_reset_led", {28'b0, led}, 32'd0);
    check("midrun_reset_mode", {30'b0, mode}, 32'd0);
    check("midrun_reset_key_press", {28'b0, key_press}, 32'd0);
    #19 sys_rst_n = 1'b1;
    wait_idle("post_reset");
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
